// File: rtl/register_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: state enum,
// bundled input/output structs and register-file geometry.
package wires;

    localparam int REGFILE_DEPTH = 32;
    localparam int ADDR_W        = 5;
    localparam int DATA_W        = 32;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_type;

    typedef struct packed {
        logic              clear_req;
        logic              a_valid;
        logic [ADDR_W-1:0] a_waddr;
        logic [DATA_W-1:0] a_wdata;
        logic              b_valid;
        logic [ADDR_W-1:0] b_waddr;
        logic [DATA_W-1:0] b_wdata;
    } arbiter_in_type;

    typedef struct packed {
        logic                     b_ready;
        logic                     busy;
        logic [REGFILE_DEPTH-1:0] pend_mask;
        logic                     wren;
        logic [ADDR_W-1:0]        waddr;
        logic [DATA_W-1:0]        wdata;
    } arbiter_out_type;

    function automatic logic [REGFILE_DEPTH-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        logic [REGFILE_DEPTH-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/register_arbiter_if.sv
// Writeback-side bus of the arbiter. B handshake: a transfer happens on a
// rising clk edge where b_valid and b_ready are both high; b_ready never
// depends on b_valid or a_valid.
interface register_arbiter_if;
    import wires::*;

    logic                     clear_req;
    logic                     a_valid;
    logic [ADDR_W-1:0]        a_waddr;
    logic [DATA_W-1:0]        a_wdata;
    logic                     b_valid;
    logic                     b_ready;
    logic [ADDR_W-1:0]        b_waddr;
    logic [DATA_W-1:0]        b_wdata;
    logic                     busy;
    logic [REGFILE_DEPTH-1:0] pend_mask;
    logic                     wren;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;

    modport master (
        output clear_req, a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        input  b_ready, busy, pend_mask, wren, waddr, wdata
    );

    modport slave (
        input  clear_req, a_valid, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        output b_ready, busy, pend_mask, wren, waddr, wdata
    );

endinterface

// File: rtl/register_arbiter_fifo.sv
// Late-writeback queue: DEPTH entries with valid/live bits, kill-by-address
// so a younger A write can cancel stale queued writes.
module regwr_fifo
    import wires::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     kill,
    input  logic [ADDR_W-1:0]        kill_addr,
    output logic                     full,
    output logic                     empty,
    output logic                     head_live,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data,
    output logic [REGFILE_DEPTH-1:0] pend_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  live_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Occupied slots are contiguous from rd_ptr, so the slot under each
    // pointer tells full/empty without a separate count.
    assign full      = valid_q[wr_ptr];
    assign empty     = !valid_q[rd_ptr];
    assign head_live = live_q[rd_ptr];
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            live_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && addr_q[i] == kill_addr) live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            // Push is younger than a same-cycle kill, so it lands live.
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                live_q[wr_ptr]  <= 1'b1;
                addr_q[wr_ptr]  <= push_addr;
                data_q[wr_ptr]  <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && live_q[i]) pend_mask = pend_mask | addr_onehot(addr_q[i]);
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: rtl/register_arbiter.sv
// Register-file write-port controller: pipeline writeback (A) has priority
// over queued late writebacks (B); sequences a full zero-clear after reset.
module register_arbiter
    import wires::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    register_arbiter_if.slave  bus,
    output arb_state_type      state_dbg
);

    arbiter_in_type  in_s;
    arbiter_out_type out_s;

    arb_state_type     state;
    logic [ADDR_W-1:0] cnt;
    logic              wren_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     head_live;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic [REGFILE_DEPTH-1:0] pend_mask;

    logic b_ready;
    logic push;
    logic arb_active;
    logic a_take;
    logic pop;

    assign in_s = '{clear_req: bus.clear_req, a_valid: bus.a_valid, a_waddr: bus.a_waddr,
                    a_wdata: bus.a_wdata, b_valid: bus.b_valid, b_waddr: bus.b_waddr,
                    b_wdata: bus.b_wdata};

    // b_ready comes from registered state only, keeping A off the B path.
    assign b_ready    = !fifo_full && (state == RUN);
    assign push       = in_s.b_valid && b_ready;
    assign arb_active = (state != CLEAR);
    assign a_take     = arb_active && in_s.a_valid;
    assign pop        = arb_active && !in_s.a_valid && !fifo_empty;

    regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (in_s.b_waddr),
        .push_data (in_s.b_wdata),
        .pop       (pop),
        .kill      (a_take),
        .kill_addr (in_s.a_waddr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data),
        .pend_mask (pend_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    wren_q  <= 1'b1;
                    waddr_q <= cnt;
                    wdata_q <= '0;
                    cnt     <= cnt + 1'b1;
                    if (cnt == ADDR_W'(REGFILE_DEPTH - 1)) state <= RUN;
                end
                RUN, DRAIN: begin
                    // x0 is hardwired zero: selected but never written.
                    if (a_take) begin
                        wren_q  <= (in_s.a_waddr != '0);
                        waddr_q <= in_s.a_waddr;
                        wdata_q <= in_s.a_wdata;
                    end else if (pop) begin
                        wren_q  <= head_live && (head_addr != '0);
                        waddr_q <= head_addr;
                        wdata_q <= head_data;
                    end else begin
                        wren_q  <= 1'b0;
                    end
                    if (state == RUN && in_s.clear_req)  state <= DRAIN;
                    else if (state == DRAIN && fifo_empty) state <= CLEAR;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign out_s = '{b_ready: b_ready, busy: (state != RUN), pend_mask: pend_mask,
                     wren: wren_q, waddr: waddr_q, wdata: wdata_q};

    assign bus.b_ready   = out_s.b_ready;
    assign bus.busy      = out_s.busy;
    assign bus.pend_mask = out_s.pend_mask;
    assign bus.wren      = out_s.wren;
    assign bus.waddr     = out_s.waddr;
    assign bus.wdata     = out_s.wdata;
    assign state_dbg     = state;

endmodule

// File: tb/tb_register_arbiter.sv
// Self-checking bench for register_arbiter: a queue-level reference model
// predicts the write stream, which a separate monitor compares on the port.
module tb_register_arbiter;
    import wires::*;

    localparam int DEPTH   = 2;
    localparam int M_CLEAR = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } ent_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    arb_state_type state_dbg;

    always #5 clk = ~clk;

    register_arbiter_if bus ();

    register_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    // exp_q entry: {cycle[68:37], waddr[36:32], wdata[31:0]}
    logic [68:0] exp_q[$];
    ent_t        mq[$];
    int          mode;
    int          clr_idx;
    bit          model_ok;
    int          cyc;
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({32'(cyc + 1), a, d});
    endtask

    // ---------------- driver + reference model ----------------
    task automatic step(input bit r, input bit cr,
                        input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit bv, input logic [4:0] ba, input logic [31:0] bd);
        bit          rdy;
        logic [31:0] pm;
        ent_t        e;
        int          nxt;
        @(negedge clk);
        rst           = r;
        bus.clear_req = cr;
        bus.a_valid   = av;
        bus.a_waddr   = aa;
        bus.a_wdata   = ad;
        bus.b_valid   = bv;
        bus.b_waddr   = ba;
        bus.b_wdata   = bd;
        #1;
        rdy = (mode == M_RUN) && (mq.size() < DEPTH);
        if (model_ok) begin
            pm = '0;
            foreach (mq[i]) if (mq[i].live && mq[i].addr != 5'd0) pm[mq[i].addr] = 1'b1;
            check("busy", 32'(bus.busy), 32'(mode != M_RUN));
            check("b_ready", 32'(bus.b_ready), 32'(rdy));
            check("pend_mask", bus.pend_mask, pm);
        end
        if (r) begin
            mode     = M_CLEAR;
            clr_idx  = 0;
            mq.delete();
            model_ok = 1'b1;
        end else if (mode == M_CLEAR) begin
            expect_write(5'(clr_idx), 32'd0);
            clr_idx++;
            if (clr_idx == REGFILE_DEPTH) begin
                mode    = M_RUN;
                clr_idx = 0;
            end
        end else begin
            nxt = mode;
            if (mode == M_RUN && cr)               nxt = M_DRAIN;
            else if (mode == M_DRAIN && mq.size() == 0) nxt = M_CLEAR;
            if (av) begin
                if (aa != 5'd0) expect_write(aa, ad);
                foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live && e.addr != 5'd0) expect_write(e.addr, e.data);
            end
            if (bv && rdy) mq.push_back('{ba, bd, 1'b1});
            mode = nxt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [68:0] e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected none (cycle %0d)",
                             bus.waddr, bus.wdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", 32'(cyc), e[68:37]);
                    check("waddr", 32'(bus.waddr), 32'(e[36:32]));
                    check("wdata", bus.wdata, e[31:0]);
                end
            end else if (exp_q.size() > 0 && exp_q[0][68:37] <= 32'(cyc)) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: got wren %b expected addr %0d data %h (cycle %0d)",
                         bus.wren, e[36:32], e[31:0], cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          av, bv, cr;
        logic [4:0]  aa, ba;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        model_ok = 1'b0;
        mode     = M_CLEAR;
        clr_idx  = 0;
        rst           = 1'b1;
        bus.clear_req = 1'b0;
        bus.a_valid   = 1'b0;
        bus.a_waddr   = '0;
        bus.a_wdata   = '0;
        bus.b_valid   = 1'b0;
        bus.b_waddr   = '0;
        bus.b_wdata   = '0;

        // reset clear
        repeat (3) step(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(34);

        // priority: B queued, A wins for two cycles
        step(0, 0, 0, 5'd0, 32'd0, 1, 5'd5, 32'hAAAA);
        step(0, 0, 1, 5'd6, 32'h1111, 0, 5'd0, 32'd0);
        step(0, 0, 1, 5'd6, 32'h1111, 0, 5'd0, 32'd0);
        idle(3);

        // full: two pushes under continuous A, third is refused
        step(0, 0, 1, 5'd3, 32'h33, 1, 5'd1, 32'h101);
        step(0, 0, 1, 5'd4, 32'h44, 1, 5'd2, 32'h202);
        step(0, 0, 1, 5'd8, 32'h88, 1, 5'd9, 32'h909);
        idle(4);

        // kill: A overwrites a queued B to the same register
        step(0, 0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h77);
        step(0, 0, 1, 5'd7, 32'h99, 0, 5'd0, 32'd0);
        idle(3);

        // same-cycle push and matching A: push survives
        step(0, 0, 1, 5'd10, 32'hA0, 1, 5'd10, 32'hB0);
        idle(3);

        // x0 from both requesters
        step(0, 0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0);
        step(0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hBEEF);
        idle(3);

        // clear request with one entry queued
        step(0, 0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h1234);
        step(0, 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(38);

        // reset mid-operation discards the queue
        step(0, 0, 1, 5'd11, 32'hB1, 1, 5'd12, 32'hC2);
        step(1, 0, 0, 5'd0, 32'd0, 1, 5'd13, 32'hD3);
        idle(36);

        // randomized traffic
        for (int i = 0; i < 900; i++) begin
            av = (mode == M_RUN) && ($urandom_range(0, 1) == 1);
            bv = ($urandom_range(0, 1) == 1);
            cr = ($urandom_range(0, 99) == 0);
            aa = 5'($urandom_range(0, 7));
            ba = 5'($urandom_range(0, 7));
            step(0, cr, av, aa, $urandom, bv, ba, $urandom);
        end
        idle(40);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
